// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial Result = inA - inB - BorrowIn, LSB first, one full-subtractor cell
// Start/Busy/Done handshake; outputs registered and held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             BorrowIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             BorrowOut,
  output logic             Overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;
  stateT state, nextState;
  logic [WIDTH-1:0] aSh, bSh, newResult;
  logic [WIDTH-2:0] dSh;
  logic [CW-1:0] cnt;
  logic brw, sA, sB, diffBit, nextBrw, lastBit;

  assign diffBit = aSh[0] ^ bSh[0] ^ brw;
  assign nextBrw = (~aSh[0] & bSh[0]) | (~(aSh[0] ^ bSh[0]) & brw);
  assign lastBit = cnt == CW'(WIDTH - 1);
  // Difference bits enter at the MSB so the final word is complete on the last edge
  assign newResult = {diffBit, dSh};

  always_ff @(posedge Clk)
    state <= !nReset ? IDLE : nextState;

  always_comb
    nextState = state == IDLE ? (Start ? RUN : IDLE) :
                state == RUN  ? (lastBit ? DONE : RUN) : IDLE;

  always_comb begin
    Busy = state == RUN;
    Done = state == DONE;
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      aSh       <= '0;
      bSh       <= '0;
      dSh       <= '0;
      brw       <= 1'b0;
      cnt       <= '0;
      sA        <= 1'b0;
      sB        <= 1'b0;
      Result    <= '0;
      BorrowOut <= 1'b0;
      Overflow  <= 1'b0;
    end else if (state == IDLE && Start) begin
      aSh <= inA;
      bSh <= inB;
      brw <= BorrowIn;
      cnt <= '0;
      sA  <= inA[WIDTH-1];
      sB  <= inB[WIDTH-1];
    end else if (state == RUN) begin
      aSh <= aSh >> 1;
      bSh <= bSh >> 1;
      dSh <= newResult[WIDTH-1:1];
      brw <= nextBrw;
      cnt <= cnt + 1'b1;
      if (lastBit) begin
        Result    <= newResult;
        BorrowOut <= nextBrw;
        Overflow  <= (sA != sB) && (newResult[WIDTH-1] != sA);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and reference-model checks of the bit-serial subtractor (WIDTH=8)
module tb_serial_subtractor;
  logic Clk = 1'b0;
  logic nReset, Start, BorrowIn, Busy, Done, BorrowOut, Overflow;
  logic [7:0] inA, inB, Result;
  int passCnt = 0;
  int checkCnt = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .inA(inA), .inB(inB),
    .BorrowIn(BorrowIn), .Busy(Busy), .Done(Done), .Result(Result),
    .BorrowOut(BorrowOut), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  // Called at a negedge in IDLE; returns at the negedge after the capture edge
  task automatic startOp(input logic [7:0] a, input logic [7:0] b, input logic bin);
    inA = a;
    inB = b;
    BorrowIn = bin;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Counts cycles until Done, bounded; flags any cycle with Busy and Done together
  task automatic waitDone(output int cyc, output bit both);
    cyc = 0;
    both = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (Busy === 1'b1 && Done === 1'b1) both = 1;
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    Start = 1'b0;
    inA = 8'hFF;
    inB = 8'h00;
    BorrowIn = 1'b1;
    repeat (3) @(negedge Clk);
    checkCnt++; if (Busy !== 1'b0) $display("FAIL reset busy: got %b want 0", Busy); else passCnt++;
    checkCnt++; if (Done !== 1'b0) $display("FAIL reset done: got %b want 0", Done); else passCnt++;
    checkCnt++; if (Result !== 8'h00) $display("FAIL reset result: got %h want 00", Result); else passCnt++;
    checkCnt++; if (BorrowOut !== 1'b0) $display("FAIL reset borrow: got %b want 0", BorrowOut); else passCnt++;
    checkCnt++; if (Overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", Overflow); else passCnt++;
    nReset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [7:0] va [5] = '{8'h50, 8'h00, 8'h05, 8'h80, 8'h7F};
    logic [7:0] vb [5] = '{8'h20, 8'h01, 8'h05, 8'h01, 8'hFF};
    logic vbin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] er [5] = '{8'h30, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic ebo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic eov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int cyc;
    bit both;
    for (int i = 0; i < 5; i++) begin
      startOp(va[i], vb[i], vbin[i]);
      checkCnt++; if ({Busy, Done} !== 2'b10) $display("FAIL basic%0d busy/done after start: got %b want 10", i, {Busy, Done}); else passCnt++;
      waitDone(cyc, both);
      checkCnt++; if (cyc !== 8) $display("FAIL basic%0d latency: got %0d want 8", i, cyc); else passCnt++;
      checkCnt++; if (Result !== er[i]) $display("FAIL basic%0d result: got %h want %h", i, Result, er[i]); else passCnt++;
      checkCnt++; if (BorrowOut !== ebo[i]) $display("FAIL basic%0d borrow: got %b want %b", i, BorrowOut, ebo[i]); else passCnt++;
      checkCnt++; if (Overflow !== eov[i]) $display("FAIL basic%0d overflow: got %b want %b", i, Overflow, eov[i]); else passCnt++;
      @(negedge Clk);
    end
  endtask

  // Start held high throughout; operands scrambled while RUN must not matter
  task automatic test_hold();
    int dones = 0;
    int unstable = 0;
    int cyc;
    bit both;
    inA = 8'h50;
    inB = 8'h20;
    BorrowIn = 1'b0;
    Start = 1'b1;
    @(negedge Clk);
    for (int c = 1; c <= 8; c++) begin
      inA = 8'($urandom);
      inB = 8'($urandom);
      BorrowIn = ~BorrowIn;
      @(negedge Clk);
      if (Done === 1'b1) dones++;
      if (c < 8 && Result !== 8'h80) unstable++;
    end
    checkCnt++; if (dones !== 1 || Done !== 1'b1) $display("FAIL hold done pulse: got %0d pulses, done=%b want 1 pulse at cycle 8", dones, Done); else passCnt++;
    checkCnt++; if (unstable !== 0) $display("FAIL hold result stable during run: got %0d changed cycles want 0", unstable); else passCnt++;
    checkCnt++; if (Result !== 8'h30) $display("FAIL hold result: got %h want 30", Result); else passCnt++;
    inA = 8'h00;
    inB = 8'h01;
    BorrowIn = 1'b0;
    @(negedge Clk);
    checkCnt++; if ({Busy, Done} !== 2'b00) $display("FAIL hold idle gap: got %b want 00", {Busy, Done}); else passCnt++;
    @(negedge Clk);
    checkCnt++; if (Busy !== 1'b1) $display("FAIL hold re-accept: got busy %b want 1", Busy); else passCnt++;
    Start = 1'b0;
    inA = 8'hAA;
    inB = 8'h55;
    waitDone(cyc, both);
    checkCnt++; if (cyc !== 8) $display("FAIL hold second latency: got %0d want 8", cyc); else passCnt++;
    checkCnt++; if ({BorrowOut, Result} !== 9'h1FF) $display("FAIL hold second result: got %b/%h want 1/ff", BorrowOut, Result); else passCnt++;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int cyc;
    bit both;
    startOp(8'h50, 8'h20, 1'b0);
    repeat (3) @(negedge Clk);
    nReset = 1'b0;
    @(negedge Clk);
    checkCnt++; if ({Busy, Done} !== 2'b00) $display("FAIL midreset busy/done: got %b want 00", {Busy, Done}); else passCnt++;
    checkCnt++; if (Result !== 8'h00) $display("FAIL midreset result: got %h want 00", Result); else passCnt++;
    checkCnt++; if ({BorrowOut, Overflow} !== 2'b00) $display("FAIL midreset flags: got %b want 00", {BorrowOut, Overflow}); else passCnt++;
    nReset = 1'b1;
    repeat (12) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) dones++;
    end
    checkCnt++; if (dones !== 0) $display("FAIL midreset abandoned op: got %0d active cycles want 0", dones); else passCnt++;
    startOp(8'h7F, 8'h01, 1'b0);
    waitDone(cyc, both);
    checkCnt++; if (cyc !== 8) $display("FAIL midreset next latency: got %0d want 8", cyc); else passCnt++;
    checkCnt++; if ({BorrowOut, Overflow, Result} !== 10'h07E) $display("FAIL midreset next result: got %b%b/%h want 00/7e", BorrowOut, Overflow, Result); else passCnt++;
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic bin, eov;
    logic [8:0] full;
    int cyc;
    bit both;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      bin = 1'($urandom_range(0, 1));
      full = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      eov = (a[7] != b[7]) && (full[7] != a[7]);
      startOp(a, b, bin);
      waitDone(cyc, both);
      checkCnt++; if (cyc !== 8 || both) $display("FAIL rand%0d timing: got %0d cycles overlap=%b want 8/0", n, cyc, both); else passCnt++;
      checkCnt++; if (Result !== full[7:0]) $display("FAIL rand%0d result %h-%h-%b: got %h want %h", n, a, b, bin, Result, full[7:0]); else passCnt++;
      checkCnt++; if (BorrowOut !== full[8]) $display("FAIL rand%0d borrow %h-%h-%b: got %b want %b", n, a, b, bin, BorrowOut, full[8]); else passCnt++;
      checkCnt++; if (Overflow !== eov) $display("FAIL rand%0d overflow %h-%h-%b: got %b want %b", n, a, b, bin, Overflow, eov); else passCnt++;
      @(negedge Clk);
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
